// File: rtl/preproc_capture_ctrl.sv
`default_nettype none
// ============================================================================
// preproc_capture_ctrl : sample-tick sequencer with source select, saturating
//                        offset and len/num packet framing on valid/ready/last.
// Revision: 1.0
// ============================================================================
module preproc_capture_ctrl #(
  parameter int ADC_WIDTH         = 14,
  parameter int NUM_SRC           = 4,
  parameter int SEL_WIDTH         = 2,
  parameter int CLOCKS_PER_SAMPLE = 3,
  parameter int LEN_WIDTH         = 16,
  parameter int NUM_WIDTH         = 8
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          cfg_start,
  input  logic                          cfg_abort,
  input  logic [LEN_WIDTH-1:0]          cfg_pkt_len,
  input  logic [NUM_WIDTH-1:0]          cfg_pkt_num,
  input  logic [SEL_WIDTH-1:0]          cfg_src_sel,
  input  logic [ADC_WIDTH-1:0]          cfg_offset,
  input  logic [NUM_SRC*ADC_WIDTH-1:0]  src_data,
  output logic [ADC_WIDTH-1:0]          m_data,
  output logic                          m_valid,
  output logic                          m_last,
  input  logic                          m_ready,
  output logic                          busy,
  output logic                          done,
  output logic                          overflow,
  output logic [NUM_WIDTH-1:0]          pkt_idx
);

  localparam int              C_DIV_W    = (CLOCKS_PER_SAMPLE > 1) ? $clog2(CLOCKS_PER_SAMPLE) : 1;
  localparam logic [C_DIV_W-1:0] C_DIV_LAST = C_DIV_W'(CLOCKS_PER_SAMPLE - 1);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_FLUSH = 2'd2
  } state_t;

  state_t                r_state;
  logic [C_DIV_W-1:0]    r_div;
  logic [LEN_WIDTH-1:0]  r_cnt;
  logic [LEN_WIDTH-1:0]  r_len;
  logic [NUM_WIDTH-1:0]  r_num;
  logic [SEL_WIDTH-1:0]  r_sel;
  logic [ADC_WIDTH-1:0]  r_off;

  logic [ADC_WIDTH-1:0]  w_src;
  logic [ADC_WIDTH:0]    w_sum;
  logic [ADC_WIDTH-1:0]  w_sat;
  logic                  w_tick;
  logic                  w_slot_free;
  logic                  w_last_smp;
  logic                  w_last_pkt;
  logic                  w_start_ok;

  always_comb begin
    w_src = '0;
    for (int i = 0; i < NUM_SRC; i++) begin
      if (r_sel == SEL_WIDTH'(i)) begin
        w_src = src_data[i*ADC_WIDTH +: ADC_WIDTH];
      end
    end
  end

  // Sign-extended sum; the two top bits disagree exactly when the result left the signed range.
  always_comb begin
    w_sum = {w_src[ADC_WIDTH-1], w_src} + {r_off[ADC_WIDTH-1], r_off};
    if (w_sum[ADC_WIDTH] != w_sum[ADC_WIDTH-1]) begin
      w_sat = w_sum[ADC_WIDTH] ? {1'b1, {(ADC_WIDTH-1){1'b0}}} : {1'b0, {(ADC_WIDTH-1){1'b1}}};
    end else begin
      w_sat = w_sum[ADC_WIDTH-1:0];
    end
  end

  assign w_tick      = (r_state == ST_RUN) && (r_div == C_DIV_LAST);
  assign w_slot_free = !m_valid || m_ready;
  assign w_last_smp  = (r_cnt == r_len - LEN_WIDTH'(1));
  assign w_last_pkt  = (pkt_idx == r_num - NUM_WIDTH'(1));
  assign w_start_ok  = cfg_start && !cfg_abort && (cfg_pkt_len != '0) && (cfg_pkt_num != '0);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state  <= ST_IDLE;
      r_div    <= '0;
      r_cnt    <= '0;
      r_len    <= '0;
      r_num    <= '0;
      r_sel    <= '0;
      r_off    <= '0;
      m_data   <= '0;
      m_valid  <= 1'b0;
      m_last   <= 1'b0;
      busy     <= 1'b0;
      done     <= 1'b0;
      overflow <= 1'b0;
      pkt_idx  <= '0;
    end else begin
      done <= 1'b0;
      if (cfg_abort && (r_state != ST_IDLE)) begin
        // overflow is deliberately kept so software can still see a lossy aborted run.
        r_state <= ST_IDLE;
        r_div   <= '0;
        r_cnt   <= '0;
        pkt_idx <= '0;
        m_valid <= 1'b0;
        m_last  <= 1'b0;
        busy    <= 1'b0;
      end else begin
        case (r_state)
          ST_IDLE: begin
            if (w_start_ok) begin
              r_len    <= cfg_pkt_len;
              r_num    <= cfg_pkt_num;
              r_sel    <= cfg_src_sel;
              r_off    <= cfg_offset;
              overflow <= 1'b0;
              r_div    <= '0;
              r_cnt    <= '0;
              pkt_idx  <= '0;
              busy     <= 1'b1;
              r_state  <= ST_RUN;
            end
          end
          ST_RUN: begin
            r_div <= w_tick ? '0 : r_div + C_DIV_W'(1);
            if (w_tick && w_slot_free) begin
              m_data  <= w_sat;
              m_valid <= 1'b1;
              m_last  <= w_last_smp;
              if (w_last_smp) begin
                // Packet boundary: the only point where source and offset may change.
                r_cnt   <= '0;
                pkt_idx <= pkt_idx + NUM_WIDTH'(1);
                r_sel   <= cfg_src_sel;
                r_off   <= cfg_offset;
                if (w_last_pkt) begin
                  r_state <= ST_FLUSH;
                end
              end else begin
                r_cnt <= r_cnt + LEN_WIDTH'(1);
              end
            end else begin
              if (w_tick) begin
                overflow <= 1'b1;
              end
              if (m_valid && m_ready) begin
                m_valid <= 1'b0;
                m_last  <= 1'b0;
              end
            end
          end
          ST_FLUSH: begin
            if (m_valid && m_ready) begin
              m_valid <= 1'b0;
              m_last  <= 1'b0;
              busy    <= 1'b0;
              done    <= 1'b1;
              r_cnt   <= '0;
              r_div   <= '0;
              pkt_idx <= '0;
              r_state <= ST_IDLE;
            end
          end
          default: begin
            r_state <= ST_IDLE;
          end
        endcase
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_preproc_capture_ctrl.sv
`default_nettype none
// ============================================================================
// tb_preproc_capture_ctrl : randomized runs scored against a packet-level model.
// Revision: 1.0
// ============================================================================
module tb_preproc_capture_ctrl;

  localparam int ADC_WIDTH = 14;
  localparam int NUM_SRC   = 4;
  localparam int SEL_WIDTH = 2;
  localparam int CPS       = 3;
  localparam int LEN_WIDTH = 16;
  localparam int NUM_WIDTH = 8;
  localparam int SMAX      = (1 << (ADC_WIDTH-1)) - 1;
  localparam int SMIN      = -(1 << (ADC_WIDTH-1));

  logic                         clk = 1'b0;
  logic                         rst_n = 1'b0;
  logic                         cfg_start = 1'b0;
  logic                         cfg_abort = 1'b0;
  logic [LEN_WIDTH-1:0]         cfg_pkt_len = '0;
  logic [NUM_WIDTH-1:0]         cfg_pkt_num = '0;
  logic [SEL_WIDTH-1:0]         cfg_src_sel = '0;
  logic [ADC_WIDTH-1:0]         cfg_offset = '0;
  logic [NUM_SRC*ADC_WIDTH-1:0] src_data = '0;
  logic [ADC_WIDTH-1:0]         m_data;
  logic                         m_valid;
  logic                         m_last;
  logic                         m_ready = 1'b0;
  logic                         busy;
  logic                         done;
  logic                         overflow;
  logic [NUM_WIDTH-1:0]         pkt_idx;

  int checks = 0;
  int errors = 0;
  int src_val [NUM_SRC];
  int g_data [$];
  bit g_last [$];

  always #5 clk = ~clk;

  preproc_capture_ctrl #(
    .ADC_WIDTH(ADC_WIDTH), .NUM_SRC(NUM_SRC), .SEL_WIDTH(SEL_WIDTH),
    .CLOCKS_PER_SAMPLE(CPS), .LEN_WIDTH(LEN_WIDTH), .NUM_WIDTH(NUM_WIDTH)
  ) dut (
    .clk(clk), .rst_n(rst_n), .cfg_start(cfg_start), .cfg_abort(cfg_abort),
    .cfg_pkt_len(cfg_pkt_len), .cfg_pkt_num(cfg_pkt_num), .cfg_src_sel(cfg_src_sel),
    .cfg_offset(cfg_offset), .src_data(src_data), .m_data(m_data), .m_valid(m_valid),
    .m_last(m_last), .m_ready(m_ready), .busy(busy), .done(done),
    .overflow(overflow), .pkt_idx(pkt_idx)
  );

  function automatic int sat(input int s, input int o);
    int r;
    r = s + o;
    if (r > SMAX) r = SMAX;
    if (r < SMIN) r = SMIN;
    return r;
  endfunction

  task automatic set_src();
    for (int i = 0; i < NUM_SRC; i++) src_data[i*ADC_WIDTH +: ADC_WIDTH] = ADC_WIDTH'(src_val[i]);
  endtask

  // One complete run. Model: a tick every CPS clocks after start; a tick is
  // taken if no beat is pending (or the pending one leaves now), else dropped.
  // Packet p>0 uses the source/offset present when packet p-1's last beat loads.
  task automatic run_capture(input int len, input int num, input int sel, input int off,
                             input int ready_pct, input int hold, input int chg_after,
                             input int chg_sel, input int mid_start, input string tag);
    int exp_data [$]; bit exp_last [$]; int exp_pkt [$];
    int got_data [$]; bit got_last [$]; int got_pkt [$];
    bit pend, run_m, seen_valid, acc, ovf_m;
    int loaded, nacc, fin_j, hold_left, m_sel, m_off;
    int valid_err, busy_err, done_cnt, done_bad;
    pend = 0; run_m = 1; seen_valid = 0; ovf_m = 0;
    loaded = 0; nacc = 0; fin_j = -1; hold_left = 0;
    valid_err = 0; busy_err = 0; done_cnt = 0; done_bad = 0;
    @(negedge clk);
    cfg_pkt_len = LEN_WIDTH'(len);
    cfg_pkt_num = NUM_WIDTH'(num);
    cfg_src_sel = SEL_WIDTH'(sel);
    cfg_offset  = ADC_WIDTH'(off);
    cfg_start   = 1'b1;
    m_ready     = 1'b0;
    m_sel = sel; m_off = off;
    @(posedge clk);
    for (int j = 1; j <= 4000; j++) begin
      @(negedge clk);
      cfg_start = (j == mid_start);
      if (done === 1'b1) begin
        done_cnt++;
        if (fin_j < 0 || j != fin_j + 1) done_bad++;
      end
      if (m_valid !== pend) valid_err++;
      if (busy !== (fin_j < 0 || j <= fin_j)) busy_err++;
      if (fin_j >= 0 && j == fin_j + 2) break;
      if (chg_after >= 0 && nacc >= chg_after) cfg_src_sel = SEL_WIDTH'(chg_sel);
      if (m_valid === 1'b1 && !seen_valid) begin
        seen_valid = 1; hold_left = hold;
      end
      if (hold_left > 0) begin
        m_ready = 1'b0; hold_left--;
      end else begin
        m_ready = (int'($urandom_range(0, 99)) < ready_pct);
      end
      acc = pend && m_ready;
      if (acc) begin
        got_data.push_back(int'($signed(m_data)));
        got_last.push_back(m_last);
        got_pkt.push_back(int'(pkt_idx));
        nacc++;
        if (nacc == len * num) fin_j = j;
      end
      if (run_m && (j % CPS == 0)) begin
        if (!pend || acc) begin
          exp_data.push_back(sat(src_val[m_sel], m_off));
          exp_last.push_back((loaded % len) == len - 1);
          exp_pkt.push_back(((loaded % len) == len - 1) ? loaded / len + 1 : loaded / len);
          loaded++;
          pend = 1;
          if (loaded % len == 0) begin
            m_sel = int'(cfg_src_sel);
            m_off = int'($signed(cfg_offset));
            if (loaded == len * num) run_m = 0;
          end
        end else begin
          ovf_m = 1;
        end
      end else if (acc) begin
        pend = 0;
      end
    end
    cfg_start = 1'b0;
    checks++;
    if (fin_j < 0) begin
      errors++; $display("FAIL %s completion: got %0d beats accepted, required %0d within cycle budget", tag, nacc, len*num);
    end
    checks++;
    if (got_data.size() != exp_data.size()) begin
      errors++; $display("FAIL %s beat_count: got %0d, expected %0d", tag, got_data.size(), exp_data.size());
    end
    for (int i = 0; i < got_data.size() && i < exp_data.size(); i++) begin
      checks++;
      if (got_data[i] !== exp_data[i] || got_last[i] !== exp_last[i] || got_pkt[i] !== exp_pkt[i]) begin
        errors++;
        $display("FAIL %s beat %0d: got data=%0d last=%0d pkt=%0d, expected data=%0d last=%0d pkt=%0d",
                 tag, i, got_data[i], got_last[i], got_pkt[i], exp_data[i], exp_last[i], exp_pkt[i]);
      end
    end
    checks++;
    if (valid_err != 0) begin
      errors++; $display("FAIL %s valid_timing: got %0d cycles off, expected 0", tag, valid_err);
    end
    checks++;
    if (busy_err != 0) begin
      errors++; $display("FAIL %s busy: got %0d cycles off, expected 0", tag, busy_err);
    end
    checks++;
    if (done_cnt != 1 || done_bad != 0) begin
      errors++; $display("FAIL %s done: got %0d pulses (%0d mistimed), expected 1", tag, done_cnt, done_bad);
    end
    checks++;
    if (overflow !== ovf_m) begin
      errors++; $display("FAIL %s overflow: got %0b, expected %0b", tag, overflow, ovf_m);
    end
    g_data = got_data;
    g_last = got_last;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    checks++; if (m_data !== '0)   begin errors++; $display("FAIL reset m_data: got %0h, expected 0", m_data); end
    checks++; if (m_valid !== 1'b0) begin errors++; $display("FAIL reset m_valid: got %0b, expected 0", m_valid); end
    checks++; if (m_last !== 1'b0)  begin errors++; $display("FAIL reset m_last: got %0b, expected 0", m_last); end
    checks++; if (busy !== 1'b0)    begin errors++; $display("FAIL reset busy: got %0b, expected 0", busy); end
    checks++; if (done !== 1'b0)    begin errors++; $display("FAIL reset done: got %0b, expected 0", done); end
    checks++; if (overflow !== 1'b0) begin errors++; $display("FAIL reset overflow: got %0b, expected 0", overflow); end
    checks++; if (pkt_idx !== '0)   begin errors++; $display("FAIL reset pkt_idx: got %0d, expected 0", pkt_idx); end
    rst_n = 1'b1;
  endtask

  task automatic test_basic();
    int bad;
    src_val[0] = 7; src_val[1] = 100; src_val[2] = -3; src_val[3] = 55;
    set_src();
    run_capture(4, 2, 1, 0, 100, 0, -1, 0, -1, "basic");
    bad = 0;
    for (int i = 0; i < g_data.size(); i++) begin
      if (g_data[i] !== 100 || g_last[i] !== ((i == 3) || (i == 7))) bad++;
    end
    checks++;
    if (g_data.size() != 8 || bad != 0) begin
      errors++; $display("FAIL basic_pattern: got %0d beats with %0d wrong, expected 8 beats of 100 with last on 4 and 8", g_data.size(), bad);
    end
    checks++;
    if (overflow !== 1'b0) begin
      errors++; $display("FAIL basic_overflow: got %0b, expected 0", overflow);
    end
  endtask

  task automatic test_saturation();
    int s_tab [3] = '{8000, -8000, -100};
    int o_tab [3] = '{500, -500, 50};
    int r_tab [3] = '{8191, -8192, -50};
    for (int k = 0; k < 3; k++) begin
      src_val[0] = s_tab[k];
      set_src();
      run_capture(1, 1, 0, o_tab[k], 100, 0, -1, 0, -1, "saturation");
      checks++;
      if (g_data.size() != 1 || g_data[0] !== r_tab[k] || g_last[0] !== 1'b1) begin
        errors++; $display("FAIL saturation case %0d: got %0d beats first=%0d, expected 1 beat of %0d with last", k, g_data.size(), (g_data.size() > 0) ? g_data[0] : 0, r_tab[k]);
      end
    end
  endtask

  task automatic test_overflow();
    src_val[0] = 1234;
    set_src();
    run_capture(4, 1, 0, 0, 100, 7, -1, 0, -1, "overflow");
    checks++;
    if (overflow !== 1'b1) begin
      errors++; $display("FAIL overflow_sticky: got %0b, expected 1", overflow);
    end
    checks++;
    if (g_data.size() != 4 || g_last[3] !== 1'b1) begin
      errors++; $display("FAIL overflow_beats: got %0d beats, expected 4 ending in last", g_data.size());
    end
  endtask

  task automatic test_src_switch();
    int bad;
    src_val[0] = 111; src_val[1] = 9; src_val[2] = -222; src_val[3] = 4;
    set_src();
    run_capture(3, 2, 0, 0, 100, 0, 1, 2, -1, "switch");
    bad = 0;
    for (int i = 0; i < g_data.size(); i++) begin
      if (g_data[i] !== ((i < 3) ? 111 : -222)) bad++;
    end
    checks++;
    if (g_data.size() != 6 || bad != 0) begin
      errors++; $display("FAIL switch_packets: got %0d beats with %0d wrong, expected 3x111 then 3x-222", g_data.size(), bad);
    end
  endtask

  task automatic test_abort();
    int dn;
    src_val[0] = 321;
    set_src();
    @(negedge clk);
    cfg_pkt_len = 16'd10; cfg_pkt_num = 8'd1; cfg_src_sel = '0; cfg_offset = '0;
    cfg_start = 1'b1; m_ready = 1'b0;
    @(negedge clk);
    cfg_start = 1'b0;
    repeat (6) @(negedge clk);
    cfg_abort = 1'b1;
    @(negedge clk);
    cfg_abort = 1'b0;
    checks++;
    if (busy !== 1'b0 || m_valid !== 1'b0 || m_last !== 1'b0 || pkt_idx !== '0) begin
      errors++; $display("FAIL abort_state: got busy=%0b valid=%0b last=%0b pkt=%0d, expected all 0", busy, m_valid, m_last, pkt_idx);
    end
    checks++;
    if (overflow !== 1'b1) begin
      errors++; $display("FAIL abort_overflow_kept: got %0b, expected 1", overflow);
    end
    dn = 0;
    repeat (5) begin
      if (done === 1'b1) dn++;
      @(negedge clk);
    end
    checks++;
    if (dn != 0) begin
      errors++; $display("FAIL abort_done: got %0d pulses, expected 0", dn);
    end
    cfg_pkt_len = 16'd2; cfg_start = 1'b1; cfg_abort = 1'b1;
    @(negedge clk);
    cfg_start = 1'b0; cfg_abort = 1'b0;
    repeat (4) @(negedge clk);
    checks++;
    if (busy !== 1'b0 || m_valid !== 1'b0) begin
      errors++; $display("FAIL abort_beats_start: got busy=%0b valid=%0b, expected 0 0", busy, m_valid);
    end
    run_capture(2, 1, 0, 0, 100, 0, -1, 0, -1, "after_abort");
    checks++;
    if (g_data.size() != 2) begin
      errors++; $display("FAIL after_abort_beats: got %0d, expected 2", g_data.size());
    end
  endtask

  task automatic test_corner();
    int bb;
    bit seen;
    bb = 0;
    @(negedge clk);
    cfg_pkt_len = 16'd0; cfg_pkt_num = 8'd3; cfg_start = 1'b1;
    @(negedge clk);
    cfg_start = 1'b0;
    repeat (3) begin if (busy !== 1'b0) bb++; @(negedge clk); end
    cfg_pkt_len = 16'd5; cfg_pkt_num = 8'd0; cfg_start = 1'b1;
    @(negedge clk);
    cfg_start = 1'b0;
    repeat (3) begin if (busy !== 1'b0) bb++; @(negedge clk); end
    checks++;
    if (bb != 0) begin
      errors++; $display("FAIL zero_len_num_start: got %0d busy cycles, expected 0", bb);
    end
    src_val[1] = -4000;
    set_src();
    run_capture(3, 2, 1, -300, 100, 0, -1, 0, 5, "start_in_run");
    checks++;
    if (g_data.size() != 6) begin
      errors++; $display("FAIL start_in_run_beats: got %0d, expected 6", g_data.size());
    end
    @(negedge clk);
    cfg_pkt_len = 16'd5; cfg_pkt_num = 8'd2; cfg_src_sel = 2'd1; cfg_start = 1'b1; m_ready = 1'b0;
    @(negedge clk);
    cfg_start = 1'b0;
    seen = 0;
    for (int i = 0; i < 20 && !seen; i++) begin
      if (m_valid === 1'b1) seen = 1; else @(negedge clk);
    end
    checks++;
    if (!seen) begin
      errors++; $display("FAIL async_reset_setup: got no valid within 20 cycles, expected a beat");
    end
    #2 rst_n = 1'b0;
    #1;
    checks++;
    if (m_data !== '0 || m_valid !== 1'b0 || m_last !== 1'b0 || busy !== 1'b0 ||
        done !== 1'b0 || overflow !== 1'b0 || pkt_idx !== '0) begin
      errors++; $display("FAIL async_reset: got data=%0h valid=%0b last=%0b busy=%0b pkt=%0d, expected all 0", m_data, m_valid, m_last, busy, pkt_idx);
    end
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_random();
    for (int r = 0; r < 8; r++) begin
      int len, num, sel, off, chg;
      for (int i = 0; i < NUM_SRC; i++) src_val[i] = int'($urandom_range(0, 16383)) - 8192;
      set_src();
      len = int'($urandom_range(1, 5));
      num = int'($urandom_range(1, 3));
      sel = int'($urandom_range(0, NUM_SRC-1));
      off = int'($urandom_range(0, 16383)) - 8192;
      chg = ($urandom_range(0, 1) == 1) ? int'($urandom_range(0, len*num-1)) : -1;
      run_capture(len, num, sel, off, int'($urandom_range(40, 100)), 0, chg,
                  int'($urandom_range(0, NUM_SRC-1)), -1, "random");
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_saturation();
    test_overflow();
    test_src_switch();
    test_abort();
    test_random();
    test_corner();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: got simulation still running, expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule
`default_nettype wire
